// File: rtl/matrix_frame_scanner.sv
// matrix_frame_scanner
//   Consumer end of the game-logic -> LED matrix image path. A full-frame
//   bitmap is accepted over valid/ready into a pending buffer. The pending
//   buffer is swapped into the display buffer only at a frame boundary, so
//   frames never tear. The display buffer is scanned one row at a time. Each
//   row is preceded by a blanking gap and is driven with 8-level PWM duty.
//
// Ports
//   clk          system clock
//   nrst         synchronous reset, active low
//   img          frame bitmap, bit r*DIM_X+c = pixel (row r, col c), 1 = lit
//   img_valid    img holds a frame to transfer
//   img_ready    pending buffer empty; transfer occurs on img_valid & img_ready
//   brightness   0 = 1/8 duty .. 7 = 8/8 duty, sampled at frame boundary
//   row          row select, one-hot while driving, polarity per ROW_ACT_LOW
//   col          column drive for the selected row, polarity per COL_ACT_LOW
//   frame_start  1-cycle pulse on the first blank cycle of row 0
module matrix_frame_scanner #(
    parameter int DIM_X       = 6,
    parameter int DIM_Y       = 6,
    parameter int ROW_HOLD    = 16,
    parameter int BLANK_CYC   = 2,
    parameter int ROW_ACT_LOW = 0,
    parameter int COL_ACT_LOW = 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [DIM_X*DIM_Y-1:0] img,
    input  logic                   img_valid,
    output logic                   img_ready,
    input  logic [2:0]             brightness,
    output logic [DIM_Y-1:0]       row,
    output logic [DIM_X-1:0]       col,
    output logic                   frame_start
);

    localparam int NPIX    = DIM_X * DIM_Y;
    localparam int CNT_MAX = (ROW_HOLD > BLANK_CYC) ? ROW_HOLD : BLANK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RW      = (DIM_Y > 1) ? $clog2(DIM_Y) : 1;

    localparam logic [DIM_Y-1:0] ROW_IDLE = (ROW_ACT_LOW != 0) ? '1 : '0;
    localparam logic [DIM_X-1:0] COL_IDLE = (COL_ACT_LOW != 0) ? '1 : '0;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [RW-1:0]   row_idx_q, row_idx_n;
    logic            started_q;
    logic            boundary;

    logic [NPIX-1:0] disp_buf;
    logic [NPIX-1:0] pend_buf;
    logic            pend_full;
    logic [2:0]      bright_q;

    logic [DIM_Y-1:0] row_act;
    logic [DIM_X-1:0] col_act;
    logic             lit;
    logic             fs_n;

    assign img_ready = ~pend_full;

    // The state/cnt/row_idx registers describe the current cycle; outputs are
    // registered from the *next* position so they line up with it without
    // an extra cycle of latency. The first cycle after reset release holds
    // at blank/row 0/cnt 0 so that it carries the frame_start pulse.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        row_idx_n = row_idx_q;
        boundary  = 1'b0;

        if (!started_q) begin
            state_n   = ST_BLANK;
            cnt_n     = '0;
            row_idx_n = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == CW'(BLANK_CYC - 1)) begin
                        state_n = ST_DRIVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CW'(ROW_HOLD - 1)) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                        if (row_idx_q == RW'(DIM_Y - 1)) begin
                            row_idx_n = '0;
                            boundary  = 1'b1;
                        end else begin
                            row_idx_n = row_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            endcase
        end

        // PWM: columns lit for the first (bright+1)/8 of the hold time.
        lit     = (32'(cnt_n) < (32'(bright_q) + 32'd1) * 32'(ROW_HOLD / 8));
        row_act = '0;
        col_act = '0;
        if (state_n == ST_DRIVE) begin
            row_act[row_idx_n] = 1'b1;
            col_act = disp_buf[int'(row_idx_n) * DIM_X +: DIM_X] & {DIM_X{lit}};
        end

        fs_n = (state_n == ST_BLANK) && (cnt_n == '0) && (row_idx_n == '0);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            row_idx_q   <= '0;
            started_q   <= 1'b0;
            disp_buf    <= '0;
            pend_buf    <= '0;
            pend_full   <= 1'b0;
            bright_q    <= 3'd7;
            row         <= ROW_IDLE;
            col         <= COL_IDLE;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            row_idx_q   <= row_idx_n;
            started_q   <= 1'b1;
            row         <= (ROW_ACT_LOW != 0) ? ~row_act : row_act;
            col         <= (COL_ACT_LOW != 0) ? ~col_act : col_act;
            frame_start <= fs_n;

            if (boundary) begin
                bright_q <= brightness;
            end

            // Swap only happens while full and capture only while empty,
            // so the two can never collide on the same edge.
            if (boundary && pend_full) begin
                disp_buf  <= pend_buf;
                pend_full <= 1'b0;
            end else if (img_valid && !pend_full) begin
                pend_buf  <= img;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_frame_scanner.sv
module tb_matrix_frame_scanner;

    localparam int DX   = 6;
    localparam int DY   = 6;
    localparam int HOLD = 16;
    localparam int BLK  = 2;
    localparam int RP   = HOLD + BLK;
    localparam int FP   = DY * RP;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [35:0] img = '0;
    logic        img_valid = 1'b0;
    logic        img_ready;
    logic [2:0]  brightness = 3'd7;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        frame_start;

    matrix_frame_scanner #(
        .DIM_X(DX),
        .DIM_Y(DY),
        .ROW_HOLD(HOLD),
        .BLANK_CYC(BLK),
        .ROW_ACT_LOW(0),
        .COL_ACT_LOW(1)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .img(img),
        .img_valid(img_valid),
        .img_ready(img_ready),
        .brightness(brightness),
        .row(row),
        .col(col),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: t = cycles since reset release (-1 while in reset).
    // Position inside the frame is derived arithmetically from t.
    int          t = -1;
    logic [35:0] m_disp = '0;
    logic [35:0] m_pend = '0;
    bit          m_full = 1'b0;
    int          m_bq = 7;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_edge();
        bit bnd;
        bit old_full;
        if (!nrst) begin
            t      = -1;
            m_disp = '0;
            m_full = 1'b0;
            m_bq   = 7;
        end else begin
            bnd      = (t >= 0) && (t % FP == FP - 1);
            old_full = m_full;
            if (bnd) begin
                m_bq = int'(brightness);
                if (old_full) begin
                    m_disp = m_pend;
                    m_full = 1'b0;
                end
            end
            if (img_valid && !old_full) begin
                m_pend = img;
                m_full = 1'b1;
            end
            t++;
        end
    endtask

    task automatic compare();
        logic [5:0] exp_row;
        logic [5:0] exp_col;
        logic [5:0] act;
        logic       exp_fs;
        int p, r, w, k;
        exp_row = '0;
        exp_col = '1;
        exp_fs  = 1'b0;
        if (t >= 0) begin
            p = t % FP;
            r = p / RP;
            w = p % RP;
            exp_fs = (p == 0);
            if (w >= BLK) begin
                k       = w - BLK;
                exp_row = 6'(1 << r);
                act     = 6'(m_disp >> (r * DX));
                if (!(k < (m_bq + 1) * (HOLD / 8))) act = '0;
                exp_col = ~act;
            end
        end
        chk("row", 36'(row), 36'(exp_row));
        chk("col", 36'(col), 36'(exp_col));
        chk("frame_start", 36'(frame_start), 36'(exp_fs));
        chk("img_ready", 36'(img_ready), 36'(!m_full));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Offer a frame for one accepted transfer; waits (bounded) for space.
    task automatic push(input logic [35:0] v);
        for (int i = 0; i < 3 * FP && m_full; i++) step();
        img       = v;
        img_valid = 1'b1;
        step();
        img_valid = 1'b0;
    endtask

    task automatic wait_pos(input int pos, input bit need_empty);
        for (int i = 0; i < 3 * FP; i++) begin
            if ((t >= 0) && (t % FP == pos) && (!need_empty || !m_full)) break;
            step();
        end
    endtask

    logic [35:0] frame_a;
    logic [35:0] frame_b;

    initial begin
        // Reset
        nrst = 1'b0;
        idle(3);
        chk("reset_ready", 36'(img_ready), 36'd1);
        nrst = 1'b1;

        // Idle scan: blank display, periodic frame_start
        idle(2 * FP + 5);

        // Single pixel (row 0, col 0)
        push(36'h0_0000_0001);
        idle(2 * FP);

        // Low brightness, full frame
        brightness = 3'd1;
        push(36'hF_FFFF_FFFF);
        idle(2 * FP + 10);
        brightness = 3'd7;

        // Back-to-back frames: B held valid while A is pending
        frame_a = {4'($urandom), $urandom};
        frame_b = {4'($urandom), $urandom};
        for (int i = 0; i < 3 * FP && m_full; i++) step();
        img       = frame_a;
        img_valid = 1'b1;
        step();
        img = frame_b;
        for (int i = 0; i < 3 * FP && m_full; i++) step();
        step();
        chk("b_accepted_pending", 36'(img_ready), 36'd0);
        img_valid = 1'b0;
        idle(2 * FP);

        // Valid raised exactly on the boundary cycle with an empty buffer
        wait_pos(FP - 1, 1'b1);
        img       = {4'($urandom), $urandom};
        img_valid = 1'b1;
        step();
        img_valid = 1'b0;
        chk("boundary_capture_full", 36'(img_ready), 36'd0);
        idle(2 * FP);

        // Reset mid row 3 while a frame is pending
        wait_pos(0, 1'b1);
        push({4'($urandom), $urandom});
        wait_pos(3 * RP + 5, 1'b0);
        nrst = 1'b0;
        step();
        chk("midreset_ready", 36'(img_ready), 36'd1);
        chk("midreset_row", 36'(row), 36'd0);
        chk("midreset_col", 36'(col), 36'h3F);
        nrst = 1'b1;
        idle(2 * FP);

        // Randomized traffic
        for (int i = 0; i < 8 * FP; i++) begin
            img_valid  = ($urandom_range(0, 3) == 0);
            img        = {4'($urandom), $urandom};
            brightness = 3'($urandom_range(0, 7));
            step();
        end
        img_valid = 1'b0;
        idle(FP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
